// File: rtl/iterative_multiplier_if.sv
// Request/response bundle between the execute-stage control unit and the
// iterative multiplier.
interface iterative_multiplier_if #(
    parameter int n = 32
);
    logic         start;
    logic [1:0]   op;
    logic [n-1:0] A;
    logic [n-1:0] B;
    logic         busy;
    logic         done;
    logic [n-1:0] result;

    modport master (output start, op, A, B, input busy, done, result);
    modport slave  (input start, op, A, B, output busy, done, result);
endinterface

// File: rtl/iterative_multiplier.sv
// Shift-add multiplier for RV32M MUL/MULH/MULHSU/MULHU: magnitudes are
// multiplied over n cycles through a ripple-carry adder, sign fixed up at the end.
module Ripple_Carry_Adder_nbit #(
    parameter int n = 32
) (
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic         Cin,
    output logic [n-1:0] S,
    output logic         Cout
);
    logic [n:0] c;

    assign c[0] = Cin;
    for (genvar i = 0; i < n; i++) begin : g_fa
        assign S[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end
    assign Cout = c[n];
endmodule

module iterative_multiplier #(
    parameter int n = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    iterative_multiplier_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;
    localparam int         CW   = $clog2(n);

    logic [1:0]     state;
    logic [2*n-1:0] prod;
    logic [n-1:0]   mcand;
    logic [CW-1:0]  cnt;
    logic           neg;
    logic [1:0]     op_q;
    logic           busy_q;
    logic           done_q;
    logic [n-1:0]   result_q;

    logic           sa;
    logic           sb;
    logic [n-1:0]   addend;
    logic [n-1:0]   sum;
    logic           cout;
    logic [2*n-1:0] prod_signed;

    function automatic logic [n-1:0] magnitude(input logic [n-1:0] v, input logic s);
        return s ? -v : v;
    endfunction

    function automatic logic [2*n-1:0] apply_sign(input logic [2*n-1:0] p, input logic s);
        return s ? -p : p;
    endfunction

    // rs1 is signed except for MULHU; rs2 is signed only for MUL and MULH
    assign sa = (bus.op != 2'b11) & bus.A[n-1];
    assign sb = ~bus.op[1] & bus.B[n-1];

    assign addend      = prod[0] ? mcand : '0;
    assign prod_signed = apply_sign(prod, neg);

    Ripple_Carry_Adder_nbit #(.n(n)) u_adder (
        .A    (prod[2*n-1:n]),
        .B    (addend),
        .Cin  (1'b0),
        .S    (sum),
        .Cout (cout)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            prod     <= '0;
            mcand    <= '0;
            cnt      <= '0;
            neg      <= 1'b0;
            op_q     <= 2'b00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand  <= magnitude(bus.A, sa);
                        prod   <= {{n{1'b0}}, magnitude(bus.B, sb)};
                        neg    <= sa ^ sb;
                        op_q   <= bus.op;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    // Carry-out becomes the new MSB as the product shifts right
                    prod <= {cout, sum, prod[n-1:1]};
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(n - 1)) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    result_q <= (op_q == 2'b00) ? prod_signed[n-1:0] : prod_signed[2*n-1:n];
                    done_q   <= 1'b1;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: doc/iterative_multiplier.md
Name: iterative_multiplier

Overview:
Multi-cycle shift-add multiplier for the RV32M MUL/MULH/MULHSU/MULHU instructions. It sits beside the ALU in the execute stage. Each iteration it drives one Ripple_Carry_Adder_nbit instance (Cin=0) with the partial product and multiplicand, then consumes its S/Cout. The control unit stalls the pipeline while busy is high and writes result back when done pulses.

Parameters:
n, 32, operand and result width in bits; the internal product is 2n bits wide.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous reset, active-low; 0 clears all state immediately
start  input  1  request a multiply; sampled only in IDLE
op  input  2  funct3[1:0]: 00 MUL (low n bits, signed x signed); 01 MULH (high, s x s); 10 MULHSU (high, s x u); 11 MULHU (high, u x u)
A  input  n  rs1 operand
B  input  n  rs2 operand
busy  output  1  high from the cycle after start is accepted until done is asserted
done  output  1  one-cycle pulse; result is valid in that cycle
result  output  n  selected product half; held until the next accepted start

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; busy=0, done=0, result=0; product register, multiplicand, counter and neg flag all cleared. Reset during RUN or FIN aborts the operation. No done is generated.
- FSM states: IDLE, RUN, FIN.
- IDLE: if start=1, latch the following and go to RUN; otherwise stay in IDLE.
  - sA = A[n-1] when op is 00, 01 or 10; else 0.
  - sB = B[n-1] when op is 00 or 01; else 0.
  - mcand = sA ? -A : A (n-bit); mplier = sB ? -B : B.
  - neg = sA XOR sB; op is latched.
  - Product register P[2n-1:0] = {n'b0, mplier}; counter = 0.
  - Magnitude of 0x80000000 is 0x80000000 as unsigned, which is correct.
- RUN, one iteration per cycle:
  - Adder inputs: A = P[2n-1:n], B = P[0] ? mcand : 0, Cin = 0.
  - Update P = {Cout, S, P[n-1:1]}.
  - counter increments; when counter == n-1 this cycle, go to FIN. RUN lasts exactly n cycles.
- FIN, one cycle:
  - If neg, the product is -P (2n-bit two's complement); else P.
  - result = product low half when op=00, high half otherwise.
  - Assert done=1, then go to IDLE.
- busy: 1 in RUN and FIN, 0 in IDLE. done and busy are registered outputs.
- Latency: start sampled at edge 0; done=1 and result valid during the cycle after edge n+1 (n+1 cycles). Back-to-back start is accepted in the cycle after done.
- start while busy=1 is ignored; A, B and op may change freely during RUN without effect.
- Multiply by 0 still takes the full n+1 cycles (no early-out).
- result changes only on the FIN-state edge or on reset.

Test Plan:
1. Reset: hold rst=0 mid-RUN -> busy=0, done=0 and result=0 immediately; after release, no done pulse appears.
2. op=00, A=7, B=6 -> done exactly n+1=33 cycles after start, result=0x0000002A; busy high for 33 cycles.
3. op=01, A=B=0x80000000 -> result=0x40000000; op=01, A=B=0xFFFFFFFF -> result=0x00000000; op=00, A=B=0xFFFFFFFF -> result=0x00000001.
4. op=11, A=B=0xFFFFFFFF -> result=0xFFFFFFFE; op=10, A=0xFFFFFFFF, B=0xFFFFFFFF -> result=0xFFFFFFFF.
5. Assert start with A=3, B=5 in cycle 10 of a running op=00 (A=2, B=9); change A/B mid-run -> result=0x00000012, only one done pulse, second start ignored.
6. Back-to-back: start in the cycle after done with op=00, A=0, B=0x12345678 -> result=0 after 33 cycles; previous result held until then.
